collmask_cfg_ctrl: RTL and testbench

- Configuration controller for the collision-pattern mask consumed by the pattern-finding stage of the trigger datapath.
- Accepts byte-wide writes from the slow-control side into a shadow register, then applies the whole 168-bit mask atomically on a commit request.
- Sequences the update under a quiesce/settle window: it drives `trig_stop` around the swap, so no partially updated mask ever reaches pattern logic.
- Sits between the configuration register bank and the trigger core; owns the `collmask` and `trig_stop` nets fed to it.

---
 rtl/collmask_cfg_ctrl.sv | 171 +++++++++++++++++
 tb/tb_collmask_cfg_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collmask_cfg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : collmask_cfg_ctrl
// Brief    : Shadow-buffered collision-mask loader with atomic quiesce/settle swap.
//            Optional byte readback of the active mask under COLLMASK_RDBK_EN.
// Revision : 1.0
// ============================================================================
module collmask_cfg_ctrl #(
    parameter int MASK_W      = 168,
    parameter int BUS_W       = 8,
    parameter int QUIESCE_CYC = 2,
    parameter int SETTLE_CYC  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [BUS_W-1:0]  wr_data,
    input  logic              commit,
    input  logic [2:0]        drifttime,
    output logic [MASK_W-1:0] collmask,
    output logic              trig_stop,
    output logic              busy,
    output logic              done,
    output logic [2:0]        err,
    input  logic              err_clr
`ifdef COLLMASK_RDBK_EN
    ,
    input  logic [4:0]        rd_addr,
    output logic [BUS_W-1:0]  rd_data
`endif
);

    localparam int                 NBYTE     = MASK_W / BUS_W;
    localparam int                 c_CNT_W   = $clog2(QUIESCE_CYC + SETTLE_CYC + 8);
    localparam logic [4:0]         c_NBYTE_A = 5'(NBYTE);
    localparam logic [c_CNT_W-1:0] c_Q_LAST  = c_CNT_W'(QUIESCE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_S_LAST  = c_CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_QUIESCE = 2'd1,
        S_APPLY   = 2'd2,
        S_SETTLE  = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]         r_drift;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               w_apply;
    logic [MASK_W-1:0]  r_collmask, r_shadow;
    logic [NBYTE-1:0]   r_bitmap, w_wr_bit;
    logic [2:0]         r_err, w_new_err;
    logic               w_idle, w_addr_ok, w_wr_ok, w_full, w_commit_ok, w_commit_bad;

    assign w_idle       = (r_state == S_IDLE);
    assign w_addr_ok    = (wr_addr < c_NBYTE_A);
    assign w_wr_ok      = wr_en & w_idle & w_addr_ok;
    assign w_wr_bit     = w_wr_ok ? (NBYTE'(1) << wr_addr) : '0;
    // A same-cycle write counts toward completeness of the shadow.
    assign w_full       = &(r_bitmap | w_wr_bit);
    assign w_commit_ok  = w_idle & commit & w_full;
    assign w_commit_bad = w_idle & commit & ~w_full;
    assign w_new_err    = {w_commit_bad, wr_en & ~w_idle, wr_en & ~w_addr_ok};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_commit_ok) begin
                    w_state_nxt = S_QUIESCE;
                    w_cnt_nxt   = '0;
                end
            end
            S_QUIESCE: begin
                if (r_cnt == c_Q_LAST) begin
                    w_state_nxt = S_APPLY;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            S_APPLY: begin
                w_apply     = 1'b1;
                w_state_nxt = S_SETTLE;
                w_cnt_nxt   = '0;
            end
            S_SETTLE: begin
                // Settle length scales with the drift time latched at commit.
                if (r_cnt == c_S_LAST + c_CNT_W'(r_drift)) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_collmask <= '1;
            r_shadow   <= '1;
            r_bitmap   <= '0;
            r_drift    <= '0;
            r_err      <= '0;
        end else begin
            if (w_wr_ok) begin
                r_shadow[int'(wr_addr)*BUS_W +: BUS_W] <= wr_data;
            end
            if (w_commit_ok) begin
                r_drift <= drifttime;
            end
            if (w_apply) begin
                r_collmask <= r_shadow;
                r_bitmap   <= '0;
            end else begin
                r_bitmap <= r_bitmap | w_wr_bit;
            end
            // A fresh error outranks a simultaneous clear.
            r_err <= (err_clr ? 3'b000 : r_err) | w_new_err;
        end
    end

`ifdef COLLMASK_RDBK_EN
    logic [BUS_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_addr < c_NBYTE_A) begin
            r_rd_data <= r_collmask[int'(rd_addr)*BUS_W +: BUS_W];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign rd_data = r_rd_data;
`else
    // Readback path absent in this build.
`endif

    assign collmask  = r_collmask;
    assign trig_stop = r_busy;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_collmask_cfg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_collmask_cfg_ctrl
// Brief    : Self-checking bench for collmask_cfg_ctrl against a cycle-timeline model.
// Revision : 1.0
// ============================================================================
module tb_collmask_cfg_ctrl;

    localparam int NB = 21;
    localparam int Q  = 2;
    localparam int S  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [4:0]   wr_addr = 5'd0;
    logic [7:0]   wr_data = 8'd0;
    logic         commit = 1'b0;
    logic [2:0]   drifttime = 3'd0;
    logic         err_clr = 1'b0;
    logic [167:0] collmask;
    logic         trig_stop, busy, done;
    logic [2:0]   err;
`ifdef COLLMASK_RDBK_EN
    logic [4:0]   rd_addr = 5'd0;
    logic [7:0]   rd_data;
    logic [7:0]   m_rd;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    collmask_cfg_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .commit    (commit),
        .drifttime (drifttime),
        .collmask  (collmask),
        .trig_stop (trig_stop),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_clr   (err_clr)
`ifdef COLLMASK_RDBK_EN
        ,
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
`endif
    );

    task automatic check(input string name, input logic [167:0] got, input logic [167:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference model: bytes as arrays, the update sequence as a window of cycle numbers.
    logic [7:0]   m_shadow [NB];
    logic [7:0]   m_active [NB];
    bit           m_bm     [NB];
    logic [2:0]   m_err;
    bit           m_seq = 1'b0;
    int           m_T = 0;
    int           m_D = 0;
    int           cyc = 0;
    bit           chk_en = 1'b0;
    int           prev;
    bit           idle, full;
    logic [2:0]   ne;
    logic [167:0] em;
    bit           e_busy, e_done;

    always @(posedge clk) begin
        prev = cyc;
        cyc  = cyc + 1;
        if (rst) begin
            for (int k = 0; k < NB; k++) begin
                m_shadow[k] = 8'hFF;
                m_active[k] = 8'hFF;
                m_bm[k]     = 1'b0;
            end
            m_err  = 3'b000;
            m_seq  = 1'b0;
            chk_en = 1'b1;
`ifdef COLLMASK_RDBK_EN
            m_rd   = 8'h00;
`endif
        end else begin
            idle = !m_seq || (prev >= m_T + Q + 2 + m_D + S);
`ifdef COLLMASK_RDBK_EN
            m_rd = (int'(rd_addr) < NB) ? m_active[rd_addr] : 8'h00;
`endif
            if (m_seq && prev == m_T + Q + 1) begin
                for (int k = 0; k < NB; k++) begin
                    m_active[k] = m_shadow[k];
                    m_bm[k]     = 1'b0;
                end
            end
            ne = 3'b000;
            if (wr_en) begin
                if (int'(wr_addr) >= NB) ne[0] = 1'b1;
                if (!idle) ne[1] = 1'b1;
                if (idle && int'(wr_addr) < NB) begin
                    m_shadow[wr_addr] = wr_data;
                    m_bm[wr_addr]     = 1'b1;
                end
            end
            if (idle && commit) begin
                full = 1'b1;
                for (int k = 0; k < NB; k++) if (!m_bm[k]) full = 1'b0;
                if (full) begin
                    m_seq = 1'b1;
                    m_T   = prev;
                    m_D   = int'(drifttime);
                end else begin
                    ne[2] = 1'b1;
                end
            end
            m_err = (err_clr ? 3'b000 : m_err) | ne;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NB; k++) em[k*8 +: 8] = m_active[k];
            e_busy = m_seq && cyc >= m_T + 1 && cyc <= m_T + Q + 1 + m_D + S;
            e_done = m_seq && cyc == m_T + Q + 2 + m_D + S;
            check("collmask", collmask, em);
            check("trig_stop", 168'(trig_stop), 168'(e_busy));
            check("busy", 168'(busy), 168'(e_busy));
            check("done", 168'(done), 168'(e_done));
            check("err", 168'(err), 168'(m_err));
`ifdef COLLMASK_RDBK_EN
            check("rd_data", 168'(rd_data), 168'(m_rd));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic load_all(input logic [7:0] base, input bit inc);
        for (int k = 0; k < NB; k++) wr(5'(k), inc ? base + 8'(k) : base);
    endtask

    task automatic do_commit(input logic [2:0] d);
        commit    = 1'b1;
        drifttime = d;
        tick();
        commit    = 1'b0;
    endtask

    int width;

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_mask", collmask, {168{1'b1}});
        check("rst_err", 168'(err), 168'(3'b000));
        check("rst_busy", 168'(busy), 168'(1'b0));

        // Full load of A5, drift 3: stop T+1..T+10, mask at T+4, done at T+11.
        load_all(8'hA5, 1'b0);
        do_commit(3'd3);
        for (int i = 1; i <= 12; i++) begin
            check("lit_stop", 168'(trig_stop), 168'(i <= 10));
            check("lit_done", 168'(done), 168'(i == 11));
            if (i == 4) check("lit_mask_t4", collmask, {21{8'hA5}});
            tick();
        end
        check("lit_err0", 168'(err), 168'(3'b000));

        // Incomplete shadow, then completion in the same cycle as commit.
        for (int k = 0; k < 20; k++) wr(5'(k), 8'h5A);
        do_commit(3'd1);
        check("lit_incomplete_err", 168'(err), 168'(3'b100));
        check("lit_incomplete_busy", 168'(busy), 168'(1'b0));
        check("lit_incomplete_mask", collmask, {21{8'hA5}});
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 8'h5A;
        do_commit(3'd1);
        wr_en = 1'b0;
        check("lit_samecyc_busy", 168'(busy), 168'(1'b1));
        repeat (12) tick();
        check("lit_samecyc_mask", collmask, {21{8'h5A}});
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("lit_errclr", 168'(err), 168'(3'b000));

        // Bad address, write during settle, clear colliding with a new error.
        wr(5'd21, 8'h77);
        check("lit_badaddr", 168'(err), 168'(3'b001));
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        load_all(8'h00, 1'b1);
        do_commit(3'd2);
        repeat (4) tick();
        wr(5'd3, 8'hFF);
        check("lit_wr_busy", 168'(err), 168'(3'b010));
        repeat (10) tick();
        check("lit_byte3", 168'(collmask[31:24]), 168'(8'h03));
        err_clr = 1'b1; wr_en = 1'b1; wr_addr = 5'd22;
        tick();
        err_clr = 1'b0; wr_en = 1'b0;
        check("lit_clr_vs_new", 168'(err), 168'(3'b001));
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        // Reset in QUIESCE and in SETTLE.
        load_all(8'h11, 1'b0);
        do_commit(3'd2);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("lit_rstq_stop", 168'(trig_stop), 168'(1'b0));
        check("lit_rstq_mask", collmask, {168{1'b1}});
        repeat (12) tick();
        load_all(8'h22, 1'b0);
        do_commit(3'd0);
        repeat (4) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("lit_rsts_busy", 168'(busy), 168'(1'b0));
        check("lit_rsts_mask", collmask, {168{1'b1}});
        repeat (12) tick();
        load_all(8'h33, 1'b1);
        do_commit(3'd4);
        repeat (16) tick();

        // Drift 0 with commit held across done.
        load_all(8'h44, 1'b1);
        commit = 1'b1; drifttime = 3'd0;
        tick();
        width = 0;
        for (int i = 1; i <= 12; i++) begin
            if (trig_stop) width++;
            tick();
        end
        commit = 1'b0;
        check("lit_width_d0", 168'(width), 168'(7));
        check("lit_held_commit_err", 168'(err), 168'(3'b100));
        err_clr = 1'b1; tick(); err_clr = 1'b0;

`ifdef COLLMASK_RDBK_EN
        load_all(8'h00, 1'b1);
        wr(5'd7, 8'h3C);
        do_commit(3'd1);
        repeat (12) tick();
        rd_addr = 5'd7; tick();
        check("lit_rd7", 168'(rd_data), 168'(8'h3C));
        rd_addr = 5'd25; tick();
        check("lit_rd25", 168'(rd_data), 168'(8'h00));
`endif

        // Randomized traffic, each round starting from a mostly complete load.
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < NB; k++)
                if ($urandom_range(0, 39) != 0) wr(5'(k), 8'($urandom));
            for (int i = 0; i < 30; i++) begin
                wr_en     = ($urandom_range(0, 2) == 0);
                wr_addr   = 5'($urandom_range(0, 23));
                wr_data   = 8'($urandom);
                commit    = ($urandom_range(0, 3) == 0);
                drifttime = 3'($urandom);
                err_clr   = ($urandom_range(0, 9) == 0);
                rst       = ($urandom_range(0, 63) == 0);
`ifdef COLLMASK_RDBK_EN
                rd_addr   = 5'($urandom_range(0, 24));
`endif
                tick();
            end
            wr_en = 1'b0; commit = 1'b0; err_clr = 1'b0; rst = 1'b0;
            repeat (16) tick();
        end

        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
